sym_vn_lut_pipe_gen: RTL and testbench
======================================

// Module: sym_vn_lut_pipe_gen
// PURPOSE
//  Parametrised symmetric 2-input IB-LUT read pipeline for the VNU datapath; PORT_NUM read ports share one two-bank LUT.
//  Folds each (y0,y1) pair by y0 sign (transpose), maps it to {page,bank}, reads t_c and re-times the transpose flag.
//  Adds per-port valid handshake, clock-enable stall, an on-chip table-load counter with ready flag, and an optional write-read bypass.
//  Sits between the CNU message mux and the VNU adder tree; the LUT is loaded in place between decoding iterations.
// PARAMETERS
//  QUAN_SIZE    4  message width in bits; y0 MSB is the sign/fold bit
//  PORT_NUM     4  number of independent read ports
//  PAGE_ADDR_W  6  page address width; must equal 2*QUAN_SIZE-2
//  TBL_NUM      2  tables selected by read/write offset; offset width = $clog2(TBL_NUM)
// PORTS
//  sys_clk              in   1                       single clock for read and write
//  rst                  in   1                       asynchronous, active-high reset
//  ce                   in   1                       pipeline advance enable; 0 = hold every pipeline register
//  in_valid             in   PORT_NUM                per-port input valid
//  transpose_en_in      in   PORT_NUM                per-port incoming transpose flag
//  y0_in                in   PORT_NUM*QUAN_SIZE      port p at [p*QUAN_SIZE +: QUAN_SIZE]
//  y1_in                in   PORT_NUM*QUAN_SIZE      same packing
//  read_offset          in   $clog2(TBL_NUM)         table select, shared by all ports
//  out_valid            out  PORT_NUM                per-port output valid
//  t_c                  out  PORT_NUM*QUAN_SIZE      LUT result, same packing as y0_in
//  transpose_en_out     out  PORT_NUM                re-timed transpose flag
//  read_offset_out      out  $clog2(TBL_NUM)         read_offset aligned with t_c
//  lut_in_bank0         in   QUAN_SIZE               write data for bank 0
//  lut_in_bank1         in   QUAN_SIZE               write data for bank 1
//  page_write_addr      in   PAGE_ADDR_W             write page
//  write_offset         in   $clog2(TBL_NUM)         write table select
//  we                   in   1                       write enable; writes both banks at {write_offset,page_write_addr}
//  lut_clr              in   1                       synchronous clear of the load counter and lut_ready
//  lut_ready            out  1                       1 when load count >= 2**PAGE_ADDR_W*TBL_NUM
// BEHAVIOUR
//  Fold (combinational, per port): f = transpose_en_in ^ y0[Q-1]; y0f = y0[Q-2:0] ^ {Q-1{y0[Q-1]}}; y1f = f ? ~y1 : y1.
//  Address: idx = {y0f, y1f} (2Q-1 bits); bank = idx[0]; page = idx[2Q-2:1]; entry = {read_offset, page}.
//  Stage 0 (ce=1): register y0f, y1f, f, in_valid and read_offset.
//  Stage 1 (ce=1): register the bank-selected memory word, f, valid and offset. Outputs are driven from stage 1.
//  Latency: exactly 2 ce-qualified edges, per port and independent. Invalid beats still flow, with out_valid=0.
//  ce=0: all pipeline registers hold, outputs stable; memory writes and the load counter still proceed.
//  Memory: TBL_NUM*2**PAGE_ADDR_W entries per bank; not reset; a write updates both banks on the rising edge.
//  Read/write same entry, same edge: the read returns the OLD word (read-before-write).
//  Load counter: +1 per we edge, saturating at 2**PAGE_ADDR_W*TBL_NUM. lut_ready = count at maximum.
//  Counter precedence: lut_clr with we clears; lut_clr wins.
//  Reset (async): every pipeline register, out_valid, t_c, transpose_en_out, read_offset_out, load counter and lut_ready go to 0.
//  Reset mid-operation: in-flight beats are dropped and out_valid stays 0 until 2 edges after the first valid beat following release.
//  Edge cases:
//   - y0=1000 (negative zero) folds to y0f=111.
//   - All-ones idx addresses page 63, bank 1 and must not wrap into the next table.
// CONFIGURATION
//  SYM_VN_LUT_WR_BYPASS_EN defined:
//   - The stage-1 read compares {read_offset,page} with the write address when we=1.
//   - On a match, the selected bank's write data is forwarded, so a same-edge hit returns the NEW word.
//  Undefined: pure read-before-write as above; no comparator logic is inferred.
// TESTING
//  1. Load: 128 we pulses, sequential pages over both offsets -> lut_ready rises on the edge of the 128th write.
//     A further we holds it at 1; lut_clr drops it to 0 next edge.
//  2. Fold: port0 y0=0011, y1=0101, transpose_en_in=0 -> entry page=0x1A, bank1; t_c appears 2 edges later; transpose_en_out=0.
//     Same with y0=1100 -> y0f=011, y1 inverted to 1010, transpose_en_out=1.
//  3. Multi-port: ports 0..3 driven with distinct valid pairs in one cycle, then in_valid=0 -> four correct t_c with out_valid=1 for one cycle.
//     out_valid then 0 while t_c follows the invalid beats.
//  4. Stall: ce=0 for 3 cycles mid-stream -> outputs frozen; after ce=1 results emerge in order with no loss or duplication.
//  5. Hazard: write page 5/off 0 with 0x9 while port0 reads the same entry on the same edge.
//     -> old value without SYM_VN_LUT_WR_BYPASS_EN; 0x9 with it defined.
//  6. Reset: assert rst between edges with 2 beats in flight -> all outputs 0 immediately; no stale out_valid after release.

Source files
------------

// File: rtl/sym_vn_lut_pipe_gen.sv
// Symmetric 2-input IB-LUT read pipeline: per-port fold, two-stage two-bank LUT read, table-load counter.
// Optional same-edge write-to-read forwarding is built when SYM_VN_LUT_WR_BYPASS_EN is defined.
module sym_vn_lut_pipe_gen #(
  parameter int  QUAN_SIZE   = 4,
  parameter int  PORT_NUM    = 4,
  parameter int  PAGE_ADDR_W = 6,
  parameter int  TBL_NUM     = 2,
  localparam int OFF_W       = (TBL_NUM > 1) ? $clog2(TBL_NUM) : 1
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic                          ce,
  input  logic [PORT_NUM-1:0]           in_valid,
  input  logic [PORT_NUM-1:0]           transpose_en_in,
  input  logic [PORT_NUM*QUAN_SIZE-1:0] y0_in,
  input  logic [PORT_NUM*QUAN_SIZE-1:0] y1_in,
  input  logic [OFF_W-1:0]              read_offset,
  output logic [PORT_NUM-1:0]           out_valid,
  output logic [PORT_NUM*QUAN_SIZE-1:0] t_c,
  output logic [PORT_NUM-1:0]           transpose_en_out,
  output logic [OFF_W-1:0]              read_offset_out,
  input  logic [QUAN_SIZE-1:0]          lut_in_bank0,
  input  logic [QUAN_SIZE-1:0]          lut_in_bank1,
  input  logic [PAGE_ADDR_W-1:0]        page_write_addr,
  input  logic [OFF_W-1:0]              write_offset,
  input  logic                          we,
  input  logic                          lut_clr,
  output logic                          lut_ready
);

  localparam int ENTRY_W = OFF_W + PAGE_ADDR_W;
  localparam int DEPTH   = TBL_NUM * (2 ** PAGE_ADDR_W);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  // Fold results (combinational, per port)
  logic [PORT_NUM-1:0]                fold_f;
  logic [PORT_NUM-1:0][QUAN_SIZE-2:0] fold_y0f;
  logic [PORT_NUM-1:0][QUAN_SIZE-1:0] fold_y1f;

  // Stage 0 registers
  logic [PORT_NUM-1:0]                s0_valid_d, s0_valid_q;
  logic [PORT_NUM-1:0]                s0_f_d, s0_f_q;
  logic [PORT_NUM-1:0][QUAN_SIZE-2:0] s0_y0f_d, s0_y0f_q;
  logic [PORT_NUM-1:0][QUAN_SIZE-1:0] s0_y1f_d, s0_y1f_q;
  logic [OFF_W-1:0]                   s0_off_d, s0_off_q;

  // Stage 1 registers (drive the outputs)
  logic [PORT_NUM-1:0]                s1_valid_d, s1_valid_q;
  logic [PORT_NUM-1:0]                s1_f_d, s1_f_q;
  logic [PORT_NUM-1:0][QUAN_SIZE-1:0] s1_tc_d, s1_tc_q;
  logic [OFF_W-1:0]                   s1_off_d, s1_off_q;

  // Read path
  logic [PORT_NUM-1:0][ENTRY_W-1:0]   rd_entry;
  logic [PORT_NUM-1:0]                rd_bank;
  logic [PORT_NUM-1:0][QUAN_SIZE-1:0] rd_word;
  logic [ENTRY_W-1:0]                 wr_entry;

  // Load counter
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             lut_ready_d, lut_ready_q;

  logic [QUAN_SIZE-1:0] mem_bank0 [DEPTH];
  logic [QUAN_SIZE-1:0] mem_bank1 [DEPTH];

  assign wr_entry = {write_offset, page_write_addr};

  // Folding by the y0 sign maps the LUT onto its symmetric half; f records whether the pair was flipped.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    fold_f   = '0;
    fold_y0f = '0;
    fold_y1f = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      fold_f[p]   = transpose_en_in[p] ^ y0_in[p*QUAN_SIZE + QUAN_SIZE-1];
      fold_y0f[p] = y0_in[p*QUAN_SIZE +: QUAN_SIZE-1]
                    ^ {(QUAN_SIZE-1){y0_in[p*QUAN_SIZE + QUAN_SIZE-1]}};
      fold_y1f[p] = fold_f[p] ? ~y1_in[p*QUAN_SIZE +: QUAN_SIZE]
                              :  y1_in[p*QUAN_SIZE +: QUAN_SIZE];
    end
  end

  always_comb begin
    s0_valid_d = s0_valid_q;
    s0_f_d     = s0_f_q;
    s0_y0f_d   = s0_y0f_q;
    s0_y1f_d   = s0_y1f_q;
    s0_off_d   = s0_off_q;
    if (ce) begin
      s0_valid_d = in_valid;
      s0_f_d     = fold_f;
      s0_y0f_d   = fold_y0f;
      s0_y1f_d   = fold_y1f;
      s0_off_d   = read_offset;
    end
  end

  // idx = {y0f, y1f}: bank is the LSB, page the remaining bits, so the entry never spills across tables.
  always_comb begin
    rd_entry = '0;
    rd_bank  = '0;
    rd_word  = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      rd_bank[p]  = s0_y1f_q[p][0];
      rd_entry[p] = {s0_off_q, s0_y0f_q[p], s0_y1f_q[p][QUAN_SIZE-1:1]};
      rd_word[p]  = rd_bank[p] ? mem_bank1[rd_entry[p]] : mem_bank0[rd_entry[p]];
`ifdef SYM_VN_LUT_WR_BYPASS_EN
      if (we && (rd_entry[p] == wr_entry)) begin
        rd_word[p] = rd_bank[p] ? lut_in_bank1 : lut_in_bank0;
      end
`endif
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_f_d     = s1_f_q;
    s1_tc_d    = s1_tc_q;
    s1_off_d   = s1_off_q;
    if (ce) begin
      s1_valid_d = s0_valid_q;
      s1_f_d     = s0_f_q;
      s1_tc_d    = rd_word;
      s1_off_d   = s0_off_q;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (lut_clr) begin
      cnt_d = '0;
    end else if (we && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
    lut_ready_d = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      s0_valid_q  <= '0;
      s0_f_q      <= '0;
      s0_y0f_q    <= '0;
      s0_y1f_q    <= '0;
      s0_off_q    <= '0;
      s1_valid_q  <= '0;
      s1_f_q      <= '0;
      s1_tc_q     <= '0;
      s1_off_q    <= '0;
      cnt_q       <= '0;
      lut_ready_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
      s0_valid_q  <= s0_valid_d;
      s0_f_q      <= s0_f_d;
      s0_y0f_q    <= s0_y0f_d;
      s0_y1f_q    <= s0_y1f_d;
      s0_off_q    <= s0_off_d;
      s1_valid_q  <= s1_valid_d;
      s1_f_q      <= s1_f_d;
      s1_tc_q     <= s1_tc_d;
      s1_off_q    <= s1_off_d;
      cnt_q       <= cnt_d;
      lut_ready_q <= lut_ready_d;
    end
  end

  // NOTE: the LUT arrays have no reset so they map onto RAM; contents are valid only once loaded.
  always_ff @(posedge sys_clk) begin
    if (we) begin
      mem_bank0[wr_entry] <= lut_in_bank0;
      mem_bank1[wr_entry] <= lut_in_bank1;
    end
  end

  assign out_valid        = s1_valid_q;
  assign t_c              = s1_tc_q;
  assign transpose_en_out = s1_f_q;
  assign read_offset_out  = s1_off_q;
  assign lut_ready        = lut_ready_q;

endmodule

// File: tb/tb_sym_vn_lut_pipe_gen.sv
// Scoreboard bench for sym_vn_lut_pipe_gen: directed fold vectors, load counter, stall, hazard and reset.
module tb_sym_vn_lut_pipe_gen;
  localparam int Q  = 4;
  localparam int P  = 4;
  localparam int PW = 6;
  localparam int OW = 1;

  logic             sys_clk = 1'b0;
  logic             rst, ce, we, lut_clr;
  logic [P-1:0]     in_valid, transpose_en_in, out_valid, transpose_en_out;
  logic [P*Q-1:0]   y0_in, y1_in, t_c;
  logic [OW-1:0]    read_offset, read_offset_out, write_offset;
  logic [Q-1:0]     lut_in_bank0, lut_in_bank1;
  logic [PW-1:0]    page_write_addr;
  logic             lut_ready;

  sym_vn_lut_pipe_gen dut (
    .sys_clk(sys_clk), .rst(rst), .ce(ce), .in_valid(in_valid),
    .transpose_en_in(transpose_en_in), .y0_in(y0_in), .y1_in(y1_in),
    .read_offset(read_offset), .out_valid(out_valid), .t_c(t_c),
    .transpose_en_out(transpose_en_out), .read_offset_out(read_offset_out),
    .lut_in_bank0(lut_in_bank0), .lut_in_bank1(lut_in_bank1),
    .page_write_addr(page_write_addr), .write_offset(write_offset),
    .we(we), .lut_clr(lut_clr), .lut_ready(lut_ready)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [Q-1:0]  tc;
    logic          f;
    logic [OW-1:0] off;
  } exp_t;

  exp_t       sb_q [P][$];
  exp_t       held [P];
  exp_t       mon_e;
  logic [P-1:0] held_valid = '0;
  logic       ce_seen;
  int         n_checks = 0;
  int         n_pass   = 0;

  localparam logic [Q-1:0] HAZ_EXP =
`ifdef SYM_VN_LUT_WR_BYPASS_EN
    4'h9;
`else
    4'h5;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Drive one port; a valid beat issued with ce=1 enters the pipeline, so its result is queued.
  task automatic drive(input int p, input logic [Q-1:0] y0, input logic [Q-1:0] y1,
                       input logic t, input logic v, input logic [Q-1:0] etc, input logic ef);
    y0_in[p*Q +: Q]    = y0;
    y1_in[p*Q +: Q]    = y1;
    transpose_en_in[p] = t;
    in_valid[p]        = v;
    if (v && ce) sb_q[p].push_back('{tc: etc, f: ef, off: read_offset});
  endtask

  always @(posedge sys_clk or posedge rst) begin
    if (rst) ce_seen <= 1'b0;
    else     ce_seen <= ce;
  end

  // Monitor: after a ce-qualified edge pop one expected result per valid port; otherwise outputs must hold.
  always @(negedge sys_clk) begin
    for (int p = 0; p < P; p++) begin
      if (ce_seen) begin
        if (out_valid[p]) begin
          if (sb_q[p].size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_valid port%0d: got out_valid=1, expected 0", p);
            held_valid[p] = 1'b0;
          end else begin
            mon_e = sb_q[p].pop_front();
            check($sformatf("t_c port%0d", p), t_c[p*Q +: Q], mon_e.tc);
            check($sformatf("transpose_out port%0d", p), transpose_en_out[p], mon_e.f);
            check($sformatf("offset_out port%0d", p), read_offset_out, mon_e.off);
            held[p]       = mon_e;
            held_valid[p] = 1'b1;
          end
        end else begin
          held_valid[p] = 1'b0;
        end
      end else begin
        check($sformatf("hold_valid port%0d", p), out_valid[p], held_valid[p]);
        if (held_valid[p] && out_valid[p]) begin
          check($sformatf("hold_t_c port%0d", p), t_c[p*Q +: Q], held[p].tc);
          check($sformatf("hold_transpose port%0d", p), transpose_en_out[p], held[p].f);
        end
      end
    end
  end

  initial begin
    logic [6:0] ev;
    rst = 1'b1; ce = 1'b1; we = 1'b0; lut_clr = 1'b0;
    in_valid = '0; transpose_en_in = '0; y0_in = '0; y1_in = '0;
    read_offset = '0; write_offset = '0; page_write_addr = '0;
    lut_in_bank0 = '0; lut_in_bank1 = '0;
    #12;
    check("rst out_valid", out_valid, 0);
    check("rst t_c", t_c, 0);
    check("rst transpose_out", transpose_en_out, 0);
    check("rst offset_out", read_offset_out, 0);
    check("rst lut_ready", lut_ready, 0);
    @(negedge sys_clk) rst = 1'b0;

    // Table load: bank0 word = entry[3:0], bank1 word = entry[6:3].
    for (int e = 0; e < 128; e++) begin
      @(negedge sys_clk);
      if (e == 127) check("lut_ready after 127 writes", lut_ready, 0);
      ev = 7'(e);
      we = 1'b1;
      write_offset    = ev[6];
      page_write_addr = ev[5:0];
      lut_in_bank0    = ev[3:0];
      lut_in_bank1    = ev[6:3];
    end
    @(negedge sys_clk);
    check("lut_ready after 128 writes", lut_ready, 1);
    write_offset = 1'b0; page_write_addr = '0; lut_in_bank0 = '0; lut_in_bank1 = '0;
    @(negedge sys_clk);
    check("lut_ready saturated", lut_ready, 1);
    we = 1'b0; lut_clr = 1'b1;
    @(negedge sys_clk);
    check("lut_ready cleared", lut_ready, 0);
    lut_clr = 1'b0;

    // Fold vectors on port 0, table 0.
    read_offset = 1'b0;
    drive(0, 4'b0011, 4'b0101, 1'b0, 1'b1, 4'h3, 1'b0);
    @(negedge sys_clk);
    drive(0, 4'b1100, 4'b0101, 1'b0, 1'b1, 4'hD, 1'b1);
    @(negedge sys_clk);
    in_valid = '0;

    // All four ports in one cycle, table 1 (port1 is negative zero -> all-ones idx).
    read_offset = 1'b1;
    drive(0, 4'b0010, 4'b0111, 1'b0, 1'b1, 4'hA, 1'b0);
    drive(1, 4'b1000, 4'b0000, 1'b0, 1'b1, 4'hF, 1'b1);
    drive(2, 4'b0101, 4'b1001, 1'b1, 1'b1, 4'hB, 1'b1);
    drive(3, 4'b1111, 4'b0011, 1'b1, 1'b1, 4'h8, 1'b0);
    @(negedge sys_clk);
    read_offset = 1'b0;
    drive(0, 4'b0011, 4'b0101, 1'b0, 1'b0, 4'h0, 1'b0);
    in_valid = '0;
    @(posedge sys_clk); @(posedge sys_clk); #1;
    check("invalid beat t_c", t_c[3:0], 4'h3);
    check("invalid beat out_valid", out_valid, 0);
    repeat (2) @(negedge sys_clk);

    // Stall: two beats enter, then ce=0 for 3 cycles with junk valid beats presented.
    drive(0, 4'b0011, 4'b0101, 1'b0, 1'b1, 4'h3, 1'b0);
    drive(1, 4'b1000, 4'b0000, 1'b0, 1'b1, 4'h7, 1'b1);
    @(negedge sys_clk);
    drive(0, 4'b1100, 4'b0101, 1'b0, 1'b1, 4'hD, 1'b1);
    drive(1, 4'b0010, 4'b0111, 1'b0, 1'b1, 4'h2, 1'b0);
    @(negedge sys_clk);
    ce = 1'b0;
    for (int p = 0; p < P; p++) drive(p, 4'b0101, 4'b0101, 1'b0, 1'b1, 4'h0, 1'b0);
    repeat (3) @(negedge sys_clk);
    ce = 1'b1;
    in_valid = '0;
    repeat (3) @(negedge sys_clk);

    // Same-edge write/read of entry {0, page 5}, then a plain read of the new word.
    drive(0, 4'b0000, 4'b1010, 1'b0, 1'b1, HAZ_EXP, 1'b0);
    @(negedge sys_clk);
    in_valid = '0;
    we = 1'b1; write_offset = 1'b0; page_write_addr = 6'd5;
    lut_in_bank0 = 4'h9; lut_in_bank1 = 4'h9;
    @(negedge sys_clk);
    we = 1'b0;
    drive(0, 4'b0000, 4'b1010, 1'b0, 1'b1, 4'h9, 1'b0);
    @(negedge sys_clk);
    in_valid = '0;
    repeat (3) @(negedge sys_clk);

    // Reset with beats in flight: outputs clear at once, no stale valid after release.
    drive(0, 4'b0011, 4'b0101, 1'b0, 1'b1, 4'h3, 1'b0);
    drive(2, 4'b1100, 4'b0101, 1'b0, 1'b1, 4'hD, 1'b1);
    @(negedge sys_clk);
    drive(0, 4'b1100, 4'b0101, 1'b0, 1'b1, 4'hD, 1'b1);
    in_valid[2] = 1'b0;
    @(negedge sys_clk);
    in_valid = '0;
    #2;
    rst = 1'b1;
    for (int p = 0; p < P; p++) sb_q[p].delete();
    held_valid = '0;
    #1;
    check("midrst out_valid", out_valid, 0);
    check("midrst t_c", t_c, 0);
    check("midrst transpose_out", transpose_en_out, 0);
    check("midrst offset_out", read_offset_out, 0);
    @(negedge sys_clk) rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    drive(3, 4'b1100, 4'b0101, 1'b0, 1'b1, 4'hD, 1'b1);
    @(negedge sys_clk);
    in_valid = '0;
    repeat (4) @(negedge sys_clk);

    for (int p = 0; p < P; p++) check($sformatf("drained port%0d", p), sb_q[p].size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
